// File: rtl/skinny_sbox_share_driver.sv
// skinny_sbox_share_driver
// ------------------------
// Issuing side of the masked Skinny S-box handshake. One shared nibble is
// accepted, held on sb_x for a clock-gated masked S-box, the S-box gating
// controller is restarted with a one-cycle sb_rst pulse, and the driver waits
// for sb_synch. The shared result is then captured and offered on a
// valid/ready interface. The S-box Fresh bus comes from an internal LFSR.
//
// Ports:
//   clk        clock shared with the S-box
//   rst        asynchronous active-low reset
//   in_valid   input shares valid
//   in_ready   driver can accept a nibble
//   in_x       input shares, share i at [4i+3:4i]
//   seed_valid load seed into the LFSR (honoured in IDLE only)
//   seed       LFSR seed (all-zero is replaced by 20'h00001)
//   sb_x       shares driven into the S-box
//   sb_fresh   fresh randomness for the S-box
//   sb_rst     active-high restart for the S-box gating controller
//   sb_y       S-box output shares
//   sb_synch   S-box result-ready pulse
//   out_valid  out_y holds a result
//   out_ready  consumer accepts the result
//   out_y      captured output shares
//   err        sticky timeout flag
module skinny_sbox_share_driver #(
  parameter int          SECURITY_ORDER = 2,
  parameter int          FRESH_WIDTH    = 20,
  parameter int          TIMEOUT        = 15,
  parameter logic [19:0] LFSR_SEED      = 20'h00001
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [4*(SECURITY_ORDER+1)-1:0] in_x,
  input  logic                          seed_valid,
  input  logic [19:0]                   seed,
  output logic [4*(SECURITY_ORDER+1)-1:0] sb_x,
  output logic [FRESH_WIDTH-1:0]        sb_fresh,
  output logic                          sb_rst,
  input  logic [4*(SECURITY_ORDER+1)-1:0] sb_y,
  input  logic                          sb_synch,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [4*(SECURITY_ORDER+1)-1:0] out_y,
  output logic                          err
);

  localparam int         CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [19:0]      lfsr;
  logic [19:0]      lfsr_next;

  // x^20 + x^17 + 1, shifting left with the feedback entering bit 0.
  assign lfsr_next = {lfsr[18:0], lfsr[19] ^ lfsr[16]};
  assign sb_fresh  = FRESH_WIDTH'(lfsr);

  // in_ready is registered, so it is low during reset and during the first
  // cycle after release; nothing is accepted while it is low.
  // sb_rst is high for exactly the START cycle, which restarts the S-box
  // gating controller while sb_x is already stable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lfsr      <= LFSR_SEED;
      sb_x      <= '0;
      out_y     <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
      sb_rst    <= 1'b1;
      in_ready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          sb_rst   <= 1'b0;
          if (in_ready && in_valid) begin
            // A simultaneous seed request is dropped: the nibble wins.
            sb_x     <= in_x;
            cnt      <= '0;
            in_ready <= 1'b0;
            sb_rst   <= 1'b1;
            state    <= START;
          end else if (in_ready && seed_valid) begin
            lfsr <= (seed == 20'h0) ? 20'h00001 : seed;
          end
        end
        START: begin
          lfsr   <= lfsr_next;
          sb_rst <= 1'b0;
          state  <= RUN;
        end
        RUN: begin
          lfsr <= lfsr_next;
          if (sb_synch) begin
            out_y     <= sb_y;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (cnt == CNT_LAST) begin
            // Give up on this nibble; err stays set until reset.
            err      <= 1'b1;
            in_ready <= 1'b1;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_skinny_sbox_share_driver.sv
// tb_skinny_sbox_share_driver
// ---------------------------
// Self-checking bench for skinny_sbox_share_driver. A behavioural S-box
// partner returns freshly re-masked shares of the Skinny S-box after a
// programmable number of RUN cycles; the bench tracks the expected LFSR
// value, err flag and recombined output from the block's described behaviour.
module tb_skinny_sbox_share_driver;

  localparam int          TIMEOUT = 15;
  localparam logic [19:0] SEED    = 20'h00001;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_x;
  logic        seed_valid;
  logic [19:0] seed;
  logic [11:0] sb_x;
  logic [19:0] sb_fresh;
  logic        sb_rst;
  logic [11:0] sb_y;
  logic        sb_synch;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_y;
  logic        err;

  int total = 0;
  int bad   = 0;

  logic [3:0]  sbox_tab [16] = '{4'hc, 4'h6, 4'h9, 4'h0, 4'h1, 4'ha, 4'h2, 4'hb,
                                 4'h3, 4'h8, 4'h5, 4'hd, 4'h4, 4'he, 4'h7, 4'hf};
  logic [19:0] fresh_m;
  logic        err_m;

  // S-box partner state
  logic        p_active = 1'b0;
  int          p_cnt    = 0;
  int          p_lat    = 1;
  bit          p_synch_en = 1'b1;
  bit          stray    = 1'b0;
  logic [11:0] p_y      = '0;

  skinny_sbox_share_driver #(
    .SECURITY_ORDER(2),
    .FRESH_WIDTH   (20),
    .TIMEOUT       (TIMEOUT),
    .LFSR_SEED     (SEED)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .seed_valid(seed_valid),
    .seed      (seed),
    .sb_x      (sb_x),
    .sb_fresh  (sb_fresh),
    .sb_rst    (sb_rst),
    .sb_y      (sb_y),
    .sb_synch  (sb_synch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] recombine(input logic [11:0] v);
    return v[3:0] ^ v[7:4] ^ v[11:8];
  endfunction

  // Re-masked shares of S(x) with two fresh masks.
  function automatic logic [11:0] make_y(input logic [11:0] x);
    logic [3:0] m0, m1;
    m0 = 4'($urandom);
    m1 = 4'($urandom);
    return {sbox_tab[recombine(x)] ^ m0 ^ m1, m1, m0};
  endfunction

  // Polynomial x^20+x^17+1 stepped n times from state s.
  function automatic logic [19:0] lfsr_adv(input logic [19:0] s, input int n);
    logic [19:0] v;
    v = s;
    for (int i = 0; i < n; i++) v = {v[18:0], v[19] ^ v[16]};
    return v;
  endfunction

  // Partner restarts while sb_rst is high and pulses synch in RUN cycle p_lat.
  always @(posedge clk) begin
    if (sb_rst) begin
      p_active <= 1'b1;
      p_cnt    <= 0;
      p_y      <= make_y(sb_x);
    end else if (p_active) begin
      if (p_cnt == p_lat) p_active <= 1'b0;
      p_cnt <= p_cnt + 1;
    end
  end

  assign sb_synch = (p_active && (p_cnt == p_lat) && p_synch_en && !sb_rst) || stray;
  assign sb_y     = p_y;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [11:0] x, input int lat, input int hold,
                       input bit seed_with, input bit seed_during);
    int          n;
    logic [11:0] y_exp;
    p_lat      = lat;
    p_synch_en = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick;
      n++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);
    in_x     = x;
    in_valid = 1'b1;
    if (seed_with) begin
      seed_valid = 1'b1;
      seed       = 20'($urandom);
    end
    tick;
    in_valid   = 1'b0;
    seed_valid = 1'b0;
    in_x       = 12'($urandom);
    check("start_sb_rst", 32'(sb_rst), 32'd1);
    check("start_in_ready", 32'(in_ready), 32'd0);
    check("start_sb_x", 32'(sb_x), 32'(x));
    check("start_fresh", 32'(sb_fresh), 32'(fresh_m));
    if (seed_during) begin
      seed_valid = 1'b1;
      seed       = 20'($urandom);
    end
    n = 0;
    while (!out_valid && n < 40) begin
      tick;
      n++;
    end
    check("latency", 32'(n), 32'(lat + 2));
    fresh_m = lfsr_adv(fresh_m, lat + 2);
    y_exp   = p_y;
    check("done_out_y", 32'(out_y), 32'(y_exp));
    check("done_recomb", 32'(recombine(out_y)), 32'(sbox_tab[recombine(x)]));
    check("done_fresh", 32'(sb_fresh), 32'(fresh_m));
    check("done_err", 32'(err), 32'(err_m));
    check("done_in_ready", 32'(in_ready), 32'd0);
    check("done_sb_x", 32'(sb_x), 32'(x));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_x     = ~x;
      tick;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_out_y", 32'(out_y), 32'(y_exp));
      check("hold_sb_x", 32'(sb_x), 32'(x));
      check("hold_fresh", 32'(sb_fresh), 32'(fresh_m));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid   = 1'b0;
    seed_valid = 1'b0;
    out_ready  = 1'b1;
    tick;
    out_ready = 1'b0;
    check("ack_valid", 32'(out_valid), 32'd0);
    check("ack_in_ready", 32'(in_ready), 32'd1);
    check("ack_fresh", 32'(sb_fresh), 32'(fresh_m));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          n;
    bit          seen;
    logic [3:0]  m0, m1;
    logic [11:0] x;

    rst        = 1'b0;
    in_valid   = 1'b0;
    in_x       = '0;
    seed_valid = 1'b0;
    seed       = '0;
    out_ready  = 1'b0;
    fresh_m    = SEED;
    err_m      = 1'b0;

    // Reset values
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_sb_rst", 32'(sb_rst), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_fresh", 32'(sb_fresh), 32'(SEED));
    check("rst_sb_x", 32'(sb_x), 32'd0);
    check("rst_out_y", 32'(out_y), 32'd0);
    rst = 1'b1;
    #1;
    check("rel_sb_rst", 32'(sb_rst), 32'd1);
    tick;
    check("edge_sb_rst", 32'(sb_rst), 32'd0);
    check("edge_in_ready", 32'(in_ready), 32'd1);

    // Directed nibble 0 as shares {6,3,5}
    do_op(12'h536, 3, 2, 1'b0, 1'b0);

    // Zero seed loads 1
    seed = 20'h0;
    seed_valid = 1'b1;
    tick;
    seed_valid = 1'b0;
    fresh_m = 20'h00001;
    check("seed_zero", 32'(sb_fresh), 32'h00001);

    // Seed 1, three advances (START + two RUN cycles)
    seed = 20'h00001;
    seed_valid = 1'b1;
    tick;
    seed_valid = 1'b0;
    fresh_m = 20'h00001;
    do_op(12'h9a7, 1, 0, 1'b0, 1'b0);
    check("seed_adv3", 32'(sb_fresh), 32'h00008);

    // Seed with nibble, and seed during operation, both ignored
    do_op(12'($urandom), 2, 3, 1'b1, 1'b1);

    // Sweep all nibbles with random share splits and latencies
    for (int nib = 0; nib < 16; nib++) begin
      m0 = 4'($urandom);
      m1 = 4'($urandom);
      x  = {4'(nib) ^ m0 ^ m1, m1, m0};
      do_op(x, int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

    // Backpressure for 10 cycles
    do_op(12'($urandom), 4, 10, 1'b0, 1'b0);

    // Stray synch in IDLE ignored
    stray = 1'b1;
    tick;
    stray = 1'b0;
    check("stray_valid", 32'(out_valid), 32'd0);
    check("stray_in_ready", 32'(in_ready), 32'd1);
    tick;
    check("stray_valid2", 32'(out_valid), 32'd0);

    // Timeout: partner never answers
    p_synch_en = 1'b0;
    in_x = 12'($urandom);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    n = 0;
    seen = 1'b0;
    while (!err && n < 40) begin
      tick;
      n++;
      if (out_valid) seen = 1'b1;
    end
    check("timeout_cycles", 32'(n), 32'(TIMEOUT));
    check("timeout_no_valid", 32'(seen), 32'd0);
    check("timeout_idle", 32'(in_ready), 32'd1);
    fresh_m = lfsr_adv(fresh_m, TIMEOUT + 1);
    check("timeout_fresh", 32'(sb_fresh), 32'(fresh_m));
    err_m = 1'b1;
    tick;
    check("err_sticky", 32'(err), 32'd1);

    // Normal operation after timeout
    do_op(12'($urandom), 2, 1, 1'b0, 1'b0);

    // Asynchronous reset in the middle of RUN
    p_lat = 8;
    in_x = 12'($urandom);
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    #3;
    rst = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd0);
    check("arst_sb_rst", 32'(sb_rst), 32'd1);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    check("arst_fresh", 32'(sb_fresh), 32'(SEED));
    check("arst_sb_x", 32'(sb_x), 32'd0);
    check("arst_out_y", 32'(out_y), 32'd0);
    fresh_m = SEED;
    err_m   = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arel_sb_rst", 32'(sb_rst), 32'd1);
    check("arel_in_ready", 32'(in_ready), 32'd0);
    tick;
    check("arel_edge_sb_rst", 32'(sb_rst), 32'd0);
    check("arel_edge_in_ready", 32'(in_ready), 32'd1);
    check("arel_fresh", 32'(sb_fresh), 32'(SEED));

    // Final operation after reset
    do_op(12'($urandom), 3, 1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
